// File: rtl/inst_align_queue_pkg.sv
// +----------------------------------------------------------------------+
// | inst_align_queue_pkg                                                 |
// | Shared types and helpers for the instruction realignment queue.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package inst_align_queue_pkg;

  typedef logic [15:0] parcel_t;

  // Low two bits of a parcel that mark the start of a 32-bit instruction.
  localparam logic [1:0] c_RVC_32BIT = 2'b11;

  function automatic bit fetch_w_legal(input int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_align_queue_parcel_fifo.sv
// +----------------------------------------------------------------------+
// | parcel_fifo                                                          |
// | Circular 16-bit parcel store: 1..P parcel writes, 2-parcel window.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module parcel_fifo
  import inst_align_queue_pkg::*;
#(
  parameter int P     = 2,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [CW-1:0]    i_wr_n,
  input  logic [16*P-1:0]  i_wr_data,
  input  logic [1:0]       i_rd_n,
  output parcel_t          o_h0,
  output parcel_t          o_h1,
  output logic [CW-1:0]    o_count
);

  parcel_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_add;

  assign w_add = i_wr_en ? i_wr_n : '0;

  // Parcel i of the write data lands at wr_ptr+i; only the first i_wr_n are kept.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < P; i++) begin
        if (i < int'(i_wr_n)) begin
          r_mem[r_wr_ptr + PW'(i)] <= i_wr_data[16*i +: 16];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_add);
      r_rd_ptr <= r_rd_ptr + PW'(i_rd_n);
      r_count  <= r_count + w_add - CW'(i_rd_n);
    end
  end

  assign o_h0    = r_mem[r_rd_ptr];
  assign o_h1    = r_mem[r_rd_ptr + PW'(1)];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/inst_align_queue.sv
// +----------------------------------------------------------------------+
// | inst_align_queue                                                     |
// | Fetch-to-decode realignment queue emitting one RV64 inst per cycle.  |
// | Compressed support enabled by defining INST_ALIGN_RVC_EN.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module inst_align_queue
  import inst_align_queue_pkg::*;
#(
  parameter int FETCH_W = 32,
  parameter int DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [63:0]        fetch_pc,
  input  logic [FETCH_W-1:0] fetch_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        pc_out,
  output logic [31:0]        inst_out,
  output logic               compressed_out
);

  localparam int P  = FETCH_W / 16;
  localparam int KB = $clog2(FETCH_W / 8);
  localparam int KW = KB - 1;
  localparam int CW = $clog2(DEPTH) + 1;

  generate
    if (!fetch_w_legal(FETCH_W)) begin : g_bad_fetch_w
      $error("inst_align_queue: FETCH_W must be 32 or 64");
    end
    if ((DEPTH < 2 * P) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("inst_align_queue: DEPTH must be a power of 2 and >= 2*P");
    end
  endgenerate

  logic [KW-1:0]      w_k;
  logic [CW-1:0]      w_wr_n;
  logic [FETCH_W-1:0] w_wr_data;
  logic               w_push;
  logic               w_pop;
  logic [1:0]         w_rd_n;
  parcel_t            w_h0;
  parcel_t            w_h1;
  logic [CW-1:0]      w_count;
  logic               w_h0_comp;
  logic [63:0]        r_head_pc;
  logic               r_pc_empty;

`ifdef INST_ALIGN_RVC_EN
  assign w_k       = fetch_pc[KB-1:1];
  assign w_h0_comp = (w_h0[1:0] != c_RVC_32BIT);
`else
  // Without RVC the entry PC is word-aligned, so only whole 32-bit slots are skipped.
  assign w_k       = fetch_pc[KB-1:1] & ~KW'(1);
  assign w_h0_comp = 1'b0;
`endif

  assign fetch_ready = !rst && ((CW'(DEPTH) - w_count) >= CW'(P));
  assign w_push      = fetch_valid && fetch_ready && !flush;
  assign w_wr_n      = CW'(P) - CW'(w_k);
  assign w_wr_data   = fetch_data >> {w_k, 4'b0000};

  parcel_fifo #(
    .P     (P),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush),
    .i_wr_en   (w_push),
    .i_wr_n    (w_wr_n),
    .i_wr_data (w_wr_data),
    .i_rd_n    (w_rd_n),
    .o_h0      (w_h0),
    .o_h1      (w_h1),
    .o_count   (w_count)
  );

  assign out_valid      = ((w_count != '0) && w_h0_comp) || (w_count >= CW'(2));
  assign compressed_out = out_valid && w_h0_comp;
  assign w_pop          = out_valid && out_ready && !flush;
  assign w_rd_n         = !w_pop ? 2'd0 : (w_h0_comp ? 2'd1 : 2'd2);
  assign pc_out         = r_head_pc;

  always_comb begin
    inst_out = 32'h0;
    if (out_valid) begin
      inst_out = w_h0_comp ? {16'h0, w_h0} : {w_h1, w_h0};
    end
  end

  // The queue is empty whenever pc_empty is set, so load and advance never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_pc  <= 64'h0;
      r_pc_empty <= 1'b1;
    end else if (flush) begin
      r_pc_empty <= 1'b1;
    end else if (w_push && r_pc_empty) begin
      r_head_pc  <= fetch_pc;
      r_pc_empty <= 1'b0;
    end else if (w_pop) begin
      r_head_pc  <= r_head_pc + (w_h0_comp ? 64'd2 : 64'd4);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_align_queue.sv
// +----------------------------------------------------------------------+
// | tb_inst_align_queue                                                  |
// | Directed and random checks against a parcel-queue reference model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_inst_align_queue;

  localparam int FETCH_W = 32;
  localparam int DEPTH   = 8;
  localparam int P       = FETCH_W / 16;
  localparam int FB      = FETCH_W / 8;
`ifdef INST_ALIGN_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  typedef logic [98:0] obs_t;  // {valid, comp, ready, inst[31:0], pc[63:0]}

  logic               clk = 1'b0;
  logic               rst, flush, fetch_valid, fetch_ready, out_valid, out_ready, compressed_out;
  logic [63:0]        fetch_pc, pc_out;
  logic [FETCH_W-1:0] fetch_data;
  logic [31:0]        inst_out;

  always #5 clk = ~clk;

  inst_align_queue #(.FETCH_W(FETCH_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_data(fetch_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .inst_out(inst_out), .compressed_out(compressed_out)
  );

  logic [15:0] mq[$];
  logic [63:0] m_pc;
  bit          m_empty;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic obs_t m_expect();
    bit          v = 1'b0;
    bit          c = 1'b0;
    logic [31:0] inst = 32'h0;
    bit          rdy = (DEPTH - mq.size()) >= P;
    if (mq.size() >= 1 && RVC && mq[0][1:0] != 2'b11) begin
      v = 1'b1; c = 1'b1; inst = {16'h0, mq[0]};
    end else if (mq.size() >= 2) begin
      v = 1'b1; inst = {mq[1], mq[0]};
    end
    return {v, c, rdy, inst, m_pc};
  endfunction

  function automatic obs_t dut_obs();
    return {out_valid, compressed_out, fetch_ready, inst_out, pc_out};
  endfunction

  // Drives one cycle of stimulus and advances the model by the same rules.
  task automatic tick(input bit fv, input logic [63:0] pc, input logic [FETCH_W-1:0] data,
                      input bit ordy, input bit fl);
    obs_t e = m_expect();
    bit   push = fv && e[96] && !fl;
    bit   pop  = e[98] && ordy && !fl;
    int   k;
    fetch_valid = fv; fetch_pc = pc; fetch_data = data; out_ready = ordy; flush = fl;
    if (fl) begin
      mq.delete();
      m_empty = 1'b1;
    end else begin
      if (pop) begin
        if (e[97]) begin
          void'(mq.pop_front()); m_pc += 2;
        end else begin
          void'(mq.pop_front()); void'(mq.pop_front()); m_pc += 4;
        end
      end
      if (push) begin
        k = RVC ? int'((pc % FB) / 2) : int'((pc % FB) / 4) * 2;
        for (int i = k; i < P; i++) mq.push_back(data[16*i +: 16]);
        if (m_empty) begin
          m_pc = pc; m_empty = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b1; fetch_pc = 64'h8000_0000;
    fetch_data = 32'h00A0_0093; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (fetch_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", fetch_ready);
    else n_pass++;
    mq.delete(); m_pc = 64'h0; m_empty = 1'b1;
    fetch_valid = 1'b0; rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dut_obs() !== {3'b001, 32'h0, 64'h0}) $display("FAIL reset_outputs: got %h want %h", dut_obs(), {3'b001, 32'h0, 64'h0});
    else n_pass++;
  endtask

  task automatic test_single();
    tick(1, 64'h8000_0000, 32'h00A0_0093, 0, 0);
    n_checks++;
    if (dut_obs() !== {3'b101, 32'h00A0_0093, 64'h8000_0000})
      $display("FAIL single_word: got %h want %h", dut_obs(), {3'b101, 32'h00A0_0093, 64'h8000_0000});
    else n_pass++;
    tick(0, 64'h0, 32'h0, 1, 0);
    n_checks++;
    if (dut_obs() !== m_expect()) $display("FAIL single_pop: got %h want %h", dut_obs(), m_expect());
    else n_pass++;
  endtask

  task automatic test_compressed_pair();
    tick(1, 64'h8000_0010, 32'h4501_4501, 1, 0);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (dut_obs() !== m_expect()) $display("FAIL compressed_pair[%0d]: got %h want %h", c, dut_obs(), m_expect());
      else n_pass++;
`ifdef INST_ALIGN_RVC_EN
      if (c < 2) begin
        n_checks++;
        if ({out_valid, compressed_out, inst_out, pc_out} !== {2'b11, 32'h4501, 64'h8000_0010 + 64'(2*c)})
          $display("FAIL compressed_const[%0d]: got %h %h", c, inst_out, pc_out);
        else n_pass++;
      end
`endif
      tick(0, 64'h0, 32'h0, 1, 0);
    end
  endtask

  task automatic test_straddle();
    tick(1, 64'h8000_0020, 32'h0093_0001, 1, 0);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (dut_obs() !== m_expect()) $display("FAIL straddle[%0d]: got %h want %h", c, dut_obs(), m_expect());
      else n_pass++;
      if (c == 1) tick(1, 64'h8000_0024, 32'h0000_00A0, 1, 0);
      else        tick(0, 64'h0, 32'h0, 1, 0);
    end
    tick(0, 64'h0, 32'h0, 0, 1);
  endtask

  task automatic test_misaligned();
`ifdef INST_ALIGN_RVC_EN
    tick(1, 64'h8000_0002, 32'h4501_FFFF, 1, 0);
    n_checks++;
    if (dut_obs() !== {3'b111, 32'h0000_4501, 64'h8000_0002})
      $display("FAIL misaligned: got %h want %h", dut_obs(), {3'b111, 32'h0000_4501, 64'h8000_0002});
    else n_pass++;
    tick(0, 64'h0, 32'h0, 1, 0);
    n_checks++;
    if (dut_obs() !== m_expect()) $display("FAIL misaligned_after: got %h want %h", dut_obs(), m_expect());
    else n_pass++;
`endif
  endtask

  task automatic test_back_pressure();
    tick(0, 64'h0, 32'h0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1, 64'h8000_0100 + 64'(4*i), 32'h00A0_0093, 0, 0);
      n_checks++;
      if (dut_obs() !== m_expect()) $display("FAIL backpressure_fill[%0d]: got %h want %h", i, dut_obs(), m_expect());
      else n_pass++;
    end
    n_checks++;
    if (fetch_ready !== 1'b0) $display("FAIL backpressure_full: got ready %b want 0", fetch_ready);
    else n_pass++;
    tick(0, 64'h0, 32'h0, 1, 0);
    n_checks++;
    if ({fetch_ready, pc_out} !== {1'b1, 64'h8000_0104})
      $display("FAIL backpressure_room: got %b %h want 1 8000000000000104", fetch_ready, pc_out);
    else n_pass++;
  endtask

  task automatic test_flush();
    tick(0, 64'h0, 32'h0, 0, 1);
    if (RVC) tick(1, 64'h8000_0202, 32'h00A0_1234, 0, 0);
    else     tick(1, 64'h8000_0200, 32'h00A0_0093, 0, 0);
    tick(1, 64'h8000_0204, 32'h00A0_0093, 0, 0);
    n_checks++;
    if (dut_obs() !== m_expect()) $display("FAIL flush_prefill: got %h want %h", dut_obs(), m_expect());
    else n_pass++;
    tick(1, 64'h8000_0208, 32'h00A0_0093, 1, 1);
    n_checks++;
    if ({out_valid, fetch_ready} !== 2'b01) $display("FAIL flush_clear: got %b want 01", {out_valid, fetch_ready});
    else n_pass++;
    tick(1, 64'h8000_1000, 32'h00A0_0093, 0, 0);
    n_checks++;
    if (dut_obs() !== {3'b101, 32'h00A0_0093, 64'h8000_1000})
      $display("FAIL flush_restart: got %h want %h", dut_obs(), {3'b101, 32'h00A0_0093, 64'h8000_1000});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] spc = 64'h8000_4000;
    bit fv, ordy, fl, acc;
    obs_t e;
    tick(0, 64'h0, 32'h0, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      fv   = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      fl   = ($urandom % 50) == 0;
      e    = m_expect();
      acc  = fv && e[96] && !fl;
      tick(fv, spc, FETCH_W'($urandom), ordy, fl);
      if (fl) spc = 64'h8000_0000 + 64'($urandom_range(0, 255) * (RVC ? 2 : 4));
      else if (acc) spc = (spc & ~64'(FB - 1)) + 64'(FB);
      n_checks++;
      if (dut_obs() !== m_expect()) $display("FAIL random[%0d]: got %h want %h", c, dut_obs(), m_expect());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_compressed_pair();
    test_straddle();
    test_misaligned();
    test_back_pressure();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_align_queue.md
# inst_align_queue

Parameterised instruction realignment queue between fetch and decode. It accepts FETCH_W-bit fetch words and splits them into 16-bit parcels in a circular buffer. It emits one whole RV64 instruction per cycle (16-bit compressed or 32-bit, including 32-bit instructions straddling fetch words) with its PC and compressed flag. It replaces direct inst_in/pc_in feeding of the ID stage, and its output feeds the decoders and the ID/EX stage register.

## Interface

- FETCH_W, 32, fetch word width; 32 or 64; P = FETCH_W/16 parcels per word
- DEPTH, 8, buffer capacity in parcels; power of 2, at least 2*P
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  clear | trap_en | bj_en, combined by the parent
- fetch_valid  in  1  fetch word offered
- fetch_ready  out  1  queue can accept a whole word
- fetch_pc  in  64  PC of the first wanted parcel; bit 0 = 0
- fetch_data  in  FETCH_W  fetch word; parcel i = bits [16i+15:16i]
- out_valid  out  1  instruction available
- out_ready  in  1  decode accepts it; driven as !stall
- pc_out  out  64  instruction PC
- inst_out  out  32  instruction; compressed form is zero-extended
- compressed_out  out  1  inst_out[1:0] != 2'b11

## Operation

- Parcel FIFO: storage[DEPTH] x 16, rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap mod DEPTH), count ($clog2(DEPTH)+1 bits).
- Push: fetch_valid & fetch_ready & !flush.
  - Skip the first k = fetch_pc[$clog2(FETCH_W/8)-1:1] parcels.
  - Write the remaining P-k parcels in order.
  - count increases by P-k.
- fetch_ready = !rst && (DEPTH - count) >= P.
- head_pc register:
  - Loaded with fetch_pc on a push when pc_empty is set.
  - Otherwise it advances by 2 (compressed) or 4 on each pop.
  - pc_empty is set by reset or flush and cleared by the first push.
  - The fetch stream between flushes is contiguous; a non-contiguous stream is a protocol violation and is not checked.
- Head parcel h0 is compressed iff h0[1:0] != 2'b11.
- out_valid = (count >= 1 && h0 compressed) || count >= 2.
- inst_out:
  - Compressed: {16'h0, h0}.
  - 32-bit: {h1, h0}.
  - Not valid: 0.
- compressed_out is 0 when !out_valid.
- pc_out = head_pc.
- Pop: out_valid & out_ready. rd_ptr and count decrease by 1 or 2.
- A push and a pop in the same cycle both apply; count changes by (pushed - popped).
- Flush: highest priority over everything in the same cycle.
  - Pointers and count go to 0 and pc_empty is set.
  - Any concurrent push or pop is discarded, including a half-received straddling instruction.
- Reset: same as flush; additionally head_pc = 0.
- Reset values: out_valid 0, pc_out 0, inst_out 0, compressed_out 0, fetch_ready 0 while rst is high and 1 in the first cycle after.

## Timing

- All outputs come from registered state; there is no combinational path from fetch_* or out_ready to the outputs.
- Latency: a word pushed in cycle N gives out_valid in cycle N+1.
- Straddle: a 32-bit instruction with only h0 buffered keeps out_valid low until the cycle after the word carrying h1 is pushed.
- Full: fetch_ready falls in the cycle after count exceeds DEPTH-P. It rises the cycle after a pop restores room.
- Throughput: one instruction per cycle. Sustained fetch at one word per cycle requires DEPTH >= 2*P.
- out_valid and the output data stay stable while out_ready is low, until a flush or reset.

## Configuration

- INST_ALIGN_RVC_EN defined:
  - Full compressed support as described above.
- INST_ALIGN_RVC_EN undefined:
  - Every instruction is two parcels and compressed_out is tied to 0.
  - out_valid = count >= 2.
  - fetch_pc must be 4-byte aligned, so k is taken only from word-offset bits above bit 1.
  - head_pc always advances by 4.

## Structure

- The isa package holds:
  - The parcel typedef (logic [15:0]).
  - The RVC-detect constant 2'b11.
  - The FETCH_W legality check function.
- One sub-module, parcel_fifo, holds:
  - Circular parcel storage.
  - Multi-parcel write of 1..P parcels, with a 2-parcel read window (h0, h1).
  - Pointers, count, and flush.
- inst_align_queue holds the head_pc and pc_empty logic, the compressed detect, and the handshakes.

## Test plan

- FETCH_W=32, DEPTH=8; push pc 0x80000000, data 0x00A00093 -> next cycle out_valid=1, pc_out 0x80000000, inst_out 0x00A00093, compressed_out 0.
- Push 0x45014501 at pc 0x80000010 with out_ready=1 -> two consecutive outputs, pc 0x80000010 then 0x80000012, inst_out 0x00004501, compressed_out 1.
- Straddle: push 0x00930001 at 0x80000020, then 0x000000A0 two cycles later:
  - First output: pc 0x80000020, inst_out 0x00000001, compressed_out 1.
  - out_valid then stays 0 until the cycle after the second push.
  - Second output: pc 0x80000022, inst_out 0x00A00093.
- Misaligned entry: push 0x4501FFFF at pc 0x80000002 -> single output at pc 0x80000002, inst_out 0x00004501; the low parcel is never seen.
- Back-pressure: out_ready=0, push 4 words of 0x00A00093 -> fetch_ready=0 with count 8. Raise out_ready for one pop -> count 6, fetch_ready=1 the next cycle.
- Flush: 3 parcels buffered, fetch_valid=1 and bj_en=1 in the same cycle -> next cycle out_valid=0 and count=0, and that word is dropped. A push of 0x00A00093 at 0x80001000 then outputs pc 0x80001000.
